branch_resolve_unit: RTL

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_pkg.sv | 22 ++
 rtl/branch_cond.sv | 29 ++
 rtl/branch_resolve_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolve unit: condition codes, control-transfer
// kinds and the output-stage state type.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_JAL    = 2'b01;
  localparam logic [1:0] KIND_JALR   = 2'b10;
  localparam logic [1:0] KIND_NONE   = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/branch_cond.sv
// Purely combinational conditional-branch comparator; reserved funct3 codes
// resolve not-taken and are flagged illegal.
module branch_cond
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  input  logic [2:0]            funct3_i,
  output logic                  taken_o,
  output logic                  illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = (rs1_i == rs2_i);
      F3_BNE:  taken_o = (rs1_i != rs2_i);
      F3_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
      F3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
      F3_BLTU: taken_o = (rs1_i <  rs2_i);
      F3_BGEU: taken_o = (rs1_i >= rs2_i);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branch/jump direction and target, compares against the fetch prediction,
// and presents the result through a one-entry valid/ready output stage with statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            kind_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic                  pred_taken_i,
  input  logic [ADDR_WIDTH-1:0] pred_target_i,
  input  logic                  flush_i,
  input  logic                  cnt_clear_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  taken_o,
  output logic [ADDR_WIDTH-1:0] target_o,
  output logic [ADDR_WIDTH-1:0] link_o,
  output logic                  mispredict_o,
  output logic                  illegal_o,
  output logic                  misalign_o,
  output logic [CNT_WIDTH-1:0]  cnt_branch_o,
  output logic [CNT_WIDTH-1:0]  cnt_taken_o,
  output logic [CNT_WIDTH-1:0]  cnt_mispred_o
);

  out_state_t            r_state;
  out_state_t            w_state_next;
  logic                  w_accept;
  logic                  w_handshake;
  logic                  w_cond_taken;
  logic                  w_cond_illegal;
  logic [DATA_WIDTH-1:0] w_jalr_sum;
  logic [ADDR_WIDTH-1:0] w_imm_addr;
  logic [ADDR_WIDTH-1:0] w_jalr_addr;
  logic [ADDR_WIDTH-1:0] w_target;
  logic [ADDR_WIDTH-1:0] w_link;
  logic                  w_taken;
  logic                  w_illegal;
  logic                  w_mispredict;
  logic                  w_misalign;

  logic                  r_taken;
  logic [ADDR_WIDTH-1:0] r_target;
  logic [ADDR_WIDTH-1:0] r_link;
  logic                  r_mispredict;
  logic                  r_illegal;
  logic                  r_misalign;
  logic                  r_is_ctrl;
  logic [CNT_WIDTH-1:0]  r_cnt_branch;
  logic [CNT_WIDTH-1:0]  r_cnt_taken;
  logic [CNT_WIDTH-1:0]  r_cnt_mispred;

  branch_cond #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cond (
    .rs1_i     (rs1_data_i),
    .rs2_i     (rs2_data_i),
    .funct3_i  (funct3_i),
    .taken_o   (w_cond_taken),
    .illegal_o (w_cond_illegal)
  );

  assign w_jalr_sum = rs1_data_i + imm_i;

  // Immediate is sign-extended into the address space; the JALR sum is an address already.
  generate
    if (DATA_WIDTH >= ADDR_WIDTH) begin : g_narrow_addr
      assign w_imm_addr  = imm_i[ADDR_WIDTH-1:0];
      assign w_jalr_addr = w_jalr_sum[ADDR_WIDTH-1:0];
    end else begin : g_wide_addr
      assign w_imm_addr  = {{(ADDR_WIDTH-DATA_WIDTH){imm_i[DATA_WIDTH-1]}}, imm_i};
      assign w_jalr_addr = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, w_jalr_sum};
    end
  endgenerate

  assign w_link = pc_i + ADDR_WIDTH'(4);

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    w_target  = pc_i + w_imm_addr;
    case (kind_i)
      KIND_BRANCH: begin
        w_taken   = w_cond_taken;
        w_illegal = w_cond_illegal;
      end
      KIND_JAL:  w_taken = 1'b1;
      KIND_JALR: begin
        w_taken  = 1'b1;
        w_target = {w_jalr_addr[ADDR_WIDTH-1:1], 1'b0};
      end
      default: w_taken = 1'b0;
    endcase
  end

  // Non-control and illegal slots never redirect fetch.
  assign w_mispredict = (kind_i != KIND_NONE) && !w_illegal &&
                        ((w_taken != pred_taken_i) || (w_taken && (w_target != pred_target_i)));
  assign w_misalign   = w_taken && (w_target[1:0] != 2'b00);

  assign valid_o     = (r_state == ST_FULL);
  assign ready_o     = (!valid_o || ready_i) && !flush_i;
  assign w_accept    = valid_i && ready_o;
  // A flushed result is discarded, so it is not counted even if the consumer is ready.
  assign w_handshake = valid_o && ready_i && !flush_i;

  always_comb begin
    w_state_next = r_state;
    if (flush_i) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
        ST_FULL:  if (ready_i && !w_accept) w_state_next = ST_EMPTY;
        default:  w_state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_taken      <= 1'b0;
      r_target     <= '0;
      r_link       <= '0;
      r_mispredict <= 1'b0;
      r_illegal    <= 1'b0;
      r_misalign   <= 1'b0;
      r_is_ctrl    <= 1'b0;
    end else if (w_accept) begin
      r_taken      <= w_taken;
      r_target     <= w_target;
      r_link       <= w_link;
      r_mispredict <= w_mispredict;
      r_illegal    <= w_illegal;
      r_misalign   <= w_misalign;
      r_is_ctrl    <= (kind_i != KIND_NONE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt_branch  <= '0;
      r_cnt_taken   <= '0;
      r_cnt_mispred <= '0;
    end else if (cnt_clear_i) begin
      r_cnt_branch  <= '0;
      r_cnt_taken   <= '0;
      r_cnt_mispred <= '0;
    end else if (w_handshake) begin
      if (r_is_ctrl && (r_cnt_branch != '1))
        r_cnt_branch <= r_cnt_branch + CNT_WIDTH'(1);
      if (r_taken && (r_cnt_taken != '1))
        r_cnt_taken <= r_cnt_taken + CNT_WIDTH'(1);
      if (r_mispredict && (r_cnt_mispred != '1))
        r_cnt_mispred <= r_cnt_mispred + CNT_WIDTH'(1);
    end
  end

  assign taken_o       = r_taken;
  assign target_o      = r_target;
  assign link_o        = r_link;
  assign mispredict_o  = r_mispredict;
  assign illegal_o     = r_illegal;
  assign misalign_o    = r_misalign;
  assign cnt_branch_o  = r_cnt_branch;
  assign cnt_taken_o   = r_cnt_taken;
  assign cnt_mispred_o = r_cnt_mispred;

endmodule
